// File: rtl/t_pulse_gen.sv
// t_pulse_gen: programmable toggle-enable sequencer for a downstream T flip-flop.
// A start request latches a spacing divider and a pulse count. The block then
// emits `count` single-cycle T pulses spaced div+1 clocks apart and ends the run
// with a one-cycle done strobe.
//
// Optional feature: define T_PULSE_GEN_ABORT_EN to add the `abort` input, which
// ends a run early.
//
// Ports:
//   clk     - rising-edge clock, shared with the TFF stage
//   reset_n - asynchronous active-low reset; clears all outputs immediately
//   start   - run request; sampled only when ready for a new run
//   div     - pulse spacing minus one; latched on an accepted start
//   count   - number of T pulses; latched on an accepted start
//   abort   - (T_PULSE_GEN_ABORT_EN only) end the current run early
//   T       - registered single-cycle toggle enable to the TFF
//   busy    - registered, high while a run is in progress
//   done    - registered one-cycle completion strobe
module t_pulse_gen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] count,
`ifdef T_PULSE_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             T,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [DIV_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic             t_nxt;
    logic             abort_req;

`ifdef T_PULSE_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        div_nxt   = div_q;
        presc_nxt = presc;
        rem_nxt   = rem;
        t_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    div_nxt   = div;
                    rem_nxt   = count;
                    presc_nxt = '0;
                end
            end
            RUN: begin
                if (rem == '0) begin
                    state_nxt = DONE;
                end else if (abort_req) begin
                    // Abort empties the pulse budget; the rem==0 path then
                    // closes the run on the next edge, so done follows a cycle later.
                    rem_nxt   = '0;
                    presc_nxt = '0;
                end else if (presc == div_q) begin
                    t_nxt     = 1'b1;
                    rem_nxt   = rem - CNT_W'(1);
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + DIV_W'(1);
                end
            end
            DONE: begin
                // The edge ending the done strobe doubles as the idle sampling
                // point, so back-to-back runs restart without a dead cycle.
                if (start) begin
                    state_nxt = RUN;
                    div_nxt   = div;
                    rem_nxt   = count;
                    presc_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            div_q <= '0;
            presc <= '0;
            rem   <= '0;
            T     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            div_q <= div_nxt;
            presc <= presc_nxt;
            rem   <= rem_nxt;
            T     <= t_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

endmodule
